// File: rtl/pcileech_sysctl_pkg.sv
// Shared types and sizing helper for the pcileech system-control block.
package pcileech_sysctl_pkg;

  typedef enum logic [1:0] {
    SC_HOLD    = 2'd0,
    SC_STAGGER = 2'd1,
    SC_RUN     = 2'd2
  } sc_state_e;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_ACT   = 2'd3
  } led_mode_e;

  // One counter width serves the sequencer and every stretch counter.
  function automatic int unsigned sc_cnt_width(input int unsigned rst_cycles,
                                               input int unsigned stagger_cycles,
                                               input int unsigned stretch_cycles);
    int unsigned m;
    m = rst_cycles;
    if (stagger_cycles > m) m = stagger_cycles;
    if (stretch_cycles > m) m = stretch_cycles;
    return $clog2(m + 1);
  endfunction

  localparam int unsigned SC_CNT_W_DEFAULT = sc_cnt_width(64, 16, 2**22);

endpackage

// File: rtl/pcileech_sysctl_led.sv
// One LED channel: mode mux, activity pulse stretcher, power-on blink overlay.
module pcileech_sysctl_led
  import pcileech_sysctl_pkg::*;
#(
  parameter int unsigned CNT_W   = 23,
  parameter int unsigned STRETCH = 2**22
) (
  input  logic      clk,
  input  logic      rst_i,
  input  logic      hold_i,
  input  led_mode_e mode_i,
  input  logic      act_i,
  input  logic      blink_i,
  input  logic      pwron_i,
  output logic      led_o
);

  localparam logic [CNT_W-1:0] STRETCH_V = CNT_W'(STRETCH);

  led_mode_e        mode_q = LED_OFF;
  logic [CNT_W-1:0] cnt_q  = '0;
  logic             led_q  = 1'b0;
  logic [CNT_W-1:0] cnt_d;
  logic             led_d;
  logic             act_eff;
  logic             clr;
  logic             base;

  always_comb begin
    act_eff = act_i & ~hold_i;
    // Any mode switch, non-activity mode or held core reset empties the stretcher.
    clr     = hold_i | (mode_i != mode_q) | (mode_i != LED_ACT);
    cnt_d   = '0;
    base    = 1'b0;
    if (!clr) begin
      if (act_eff)            cnt_d = STRETCH_V;
      else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
    end
    case (mode_i)
      LED_OFF:   base = 1'b0;
      LED_ON:    base = 1'b1;
      LED_BLINK: base = blink_i;
      LED_ACT:   base = act_eff | ((cnt_q != '0) & ~clr);
      default:   base = 1'b0;
    endcase
    led_d = base ^ pwron_i;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      mode_q <= LED_OFF;
      cnt_q  <= '0;
      led_q  <= 1'b0;
    end else begin
      mode_q <= mode_i;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/pcileech_sysctl.sv
// System control: 64-bit tick counter, staged core/com reset sequencer, LED bank.
// Optional soft reset request enabled by defining PCILEECH_SYSCTL_SOFTRST_EN.
module pcileech_sysctl
  import pcileech_sysctl_pkg::*;
#(
  parameter int unsigned PARAM_NUM_LED        = 2,
  parameter int unsigned PARAM_RST_CYCLES     = 64,
  parameter int unsigned PARAM_STAGGER_CYCLES = 16,
  parameter int unsigned PARAM_BLINK_LOG2     = 24,
  parameter int unsigned PARAM_STRETCH_CYCLES = 2**22
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       soft_rst_req,
  output logic [63:0]                tickcount64,
  output logic                       rst_core,
  output logic                       rst_com_n,
  input  logic [2*PARAM_NUM_LED-1:0] led_mode,
  input  logic [PARAM_NUM_LED-1:0]   led_act,
  output logic                       pwron_blink,
  output logic [PARAM_NUM_LED-1:0]   led_out
);

  localparam int unsigned CNT_W = sc_cnt_width(PARAM_RST_CYCLES, PARAM_STAGGER_CYCLES,
                                               PARAM_STRETCH_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PARAM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STG_LAST =
    CNT_W'((PARAM_STAGGER_CYCLES > 0) ? PARAM_STAGGER_CYCLES - 1 : 0);

  // NOTE: declaration initialisers become FPGA configuration values equal to the reset
  // values, so the block sequences itself out of configuration without rst.
  logic [63:0]      tick_q      = '0;
  logic             pwron_q     = 1'b0;
  sc_state_e        state_q     = SC_HOLD;
  logic [CNT_W-1:0] cnt_q       = '0;
  logic             rst_core_q  = 1'b1;
  logic             rst_com_n_q = 1'b0;

  sc_state_e        state_d;
  logic [CNT_W-1:0] cnt_d;
  logic             rst_core_d;
  logic             rst_com_n_d;
  logic             pwron_d;
  logic             trig;

`ifdef PCILEECH_SYSCTL_SOFTRST_EN
  assign trig = rst | soft_rst_req;
`else
  logic unused_soft_rst_req;
  assign unused_soft_rst_req = soft_rst_req;
  assign trig                = rst;
`endif

  // Blink for the first 2^(B+3) ticks after clear: four on/off periods.
  assign pwron_d = tick_q[PARAM_BLINK_LOG2] & ~|tick_q[63:PARAM_BLINK_LOG2+3];

  // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q  <= '0;
      pwron_q <= 1'b0;
    end else begin
      tick_q  <= tick_q + 64'd1;
      pwron_q <= pwron_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SC_HOLD;
      cnt_q       <= '0;
      rst_core_q  <= 1'b1;
      rst_com_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_core_q  <= rst_core_d;
      rst_com_n_q <= rst_com_n_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    if (trig) begin
      state_d = SC_HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SC_HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_d = (PARAM_STAGGER_CYCLES == 0) ? SC_RUN : SC_STAGGER;
            cnt_d   = '0;
          end
        end
        SC_STAGGER: begin
          if (cnt_q == STG_LAST) begin
            state_d = SC_RUN;
            cnt_d   = '0;
          end
        end
        SC_RUN:  cnt_d = '0;
        default: begin
          state_d = SC_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    rst_core_d  = 1'b1;
    rst_com_n_d = 1'b0;
    case (state_d)
      SC_STAGGER: rst_com_n_d = 1'b1;
      SC_RUN: begin
        rst_core_d  = 1'b0;
        rst_com_n_d = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < PARAM_NUM_LED; i++) begin : g_led
    pcileech_sysctl_led #(
      .CNT_W   (CNT_W),
      .STRETCH (PARAM_STRETCH_CYCLES)
    ) u_led (
      .clk     (clk),
      .rst_i   (rst),
      .hold_i  (rst_core_q),
      .mode_i  (led_mode_e'(led_mode[2*i +: 2])),
      .act_i   (led_act[i]),
      .blink_i (tick_q[PARAM_BLINK_LOG2]),
      .pwron_i (pwron_d),
      .led_o   (led_out[i])
    );
  end

  assign tickcount64 = tick_q;
  assign rst_core    = rst_core_q;
  assign rst_com_n   = rst_com_n_q;
  assign pwron_blink = pwron_q;

endmodule

// File: tb/tb_pcileech_sysctl.sv
// Scoreboard bench for pcileech_sysctl: cycle-level reference model feeds an
// expectation queue that a posedge monitor drains against the DUT outputs.
module tb_pcileech_sysctl;

  localparam int NL   = 2;
  localparam int RSTC = 64;
  localparam int STG  = 16;
  localparam int BL   = 4;
  localparam int STR  = 8;
`ifdef PCILEECH_SYSCTL_SOFTRST_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic              clk          = 1'b0;
  logic              rst          = 1'b1;
  logic              soft_rst_req = 1'b0;
  logic [2*NL-1:0]   led_mode     = '0;
  logic [NL-1:0]     led_act      = '0;
  logic [63:0]       tickcount64;
  logic              rst_core;
  logic              rst_com_n;
  logic              pwron_blink;
  logic [NL-1:0]     led_out;

  pcileech_sysctl #(
    .PARAM_NUM_LED        (NL),
    .PARAM_RST_CYCLES     (RSTC),
    .PARAM_STAGGER_CYCLES (STG),
    .PARAM_BLINK_LOG2     (BL),
    .PARAM_STRETCH_CYCLES (STR)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .tickcount64  (tickcount64),
    .rst_core     (rst_core),
    .rst_com_n    (rst_com_n),
    .led_mode     (led_mode),
    .led_act      (led_act),
    .pwron_blink  (pwron_blink),
    .led_out      (led_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]   tick;
    logic          core;
    logic          com_n;
    logic          pw;
    logic [NL-1:0] led;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: time since the last reset trigger decides both resets.
  logic [63:0] m_tick  = '0;
  int          m_since = 0;
  logic        m_core  = 1'b1;
  int          m_cyc   = 0;
  int          m_last  [NL];
  bit          m_valid [NL];
  logic [1:0]  m_prev  [NL];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already driven: predicts the next posedge.
  task automatic step();
    obs_t          e;
    logic [63:0]   t;
    logic          pw;
    logic [NL-1:0] led;
    logic [1:0]    m;
    logic          a, b, fresh;
    t   = m_tick;
    pw  = 1'b0;
    led = '0;
    if (rst) begin
      m_tick  = '0;
      m_since = 0;
      for (int i = 0; i < NL; i++) begin
        m_valid[i] = 1'b0;
        m_prev[i]  = 2'b00;
      end
    end else begin
      pw = (((t >> BL) & 64'd1) == 64'd1) && (t < 64'd128);
      for (int i = 0; i < NL; i++) begin
        m = led_mode[2*i +: 2];
        a = led_act[i] && !m_core;
        b = 1'b0;
        case (m)
          2'b01: b = 1'b1;
          2'b10: b = (((t >> BL) & 64'd1) == 64'd1);
          2'b11: begin
            fresh = (m == m_prev[i]) && !m_core && m_valid[i] && (m_cyc - m_last[i] <= STR);
            b = a || fresh;
            if (m != m_prev[i] || m_core) m_valid[i] = 1'b0;
            else if (a) begin
              m_valid[i] = 1'b1;
              m_last[i]  = m_cyc;
            end
          end
          default: b = 1'b0;
        endcase
        if (m != 2'b11) m_valid[i] = 1'b0;
        m_prev[i] = m;
        led[i]    = b ^ pw;
      end
      m_tick = t + 64'd1;
      if (soft_rst_req && SOFT_EN) m_since = 0;
      else if (m_since < 100000)   m_since++;
    end
    m_core  = (m_since < RSTC + STG);
    e.tick  = m_tick;
    e.core  = m_core;
    e.com_n = (m_since >= RSTC);
    e.pw    = pw;
    e.led   = led;
    exp_q.push_back(e);
    m_cyc++;
    @(negedge clk);
  endtask

  initial begin : monitor
    obs_t e;
    obs_t got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e         = exp_q.pop_front();
        got.tick  = tickcount64;
        got.core  = rst_core;
        got.com_n = rst_com_n;
        got.pw    = pwron_blink;
        got.led   = led_out;
        check("cycle_outputs", 128'(got), 128'(e));
      end
    end
  end

  task automatic wait_release(output logic [63:0] t_com, output logic [63:0] t_core,
                              output logic ok);
    bit seen;
    seen   = 1'b0;
    ok     = 1'b0;
    t_com  = '1;
    t_core = '1;
    for (int k = 0; k < 300; k++) begin
      if (!seen && rst_com_n) begin
        seen  = 1'b1;
        t_com = tickcount64;
      end
      if (!rst_core) begin
        ok     = 1'b1;
        t_core = tickcount64;
        break;
      end
      step();
    end
  endtask

  initial begin : stim
    logic [63:0] tc, tf, t0;
    logic        ok;
    int          cnt;
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_prev[i]  = 2'b00;
      m_last[i]  = 0;
    end
    @(negedge clk);

    // Reset held three cycles; LED0 on, LED1 blink so the power-on blink shows in HOLD.
    led_mode = {2'b10, 2'b01};
    rst      = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    wait_release(tc, tf, ok);
    check("s1_release_seen", 128'(ok), 128'(1));
    check("s1_com_release_tick", 128'(tc), 128'(64));
    check("s1_core_release_tick", 128'(tf), 128'(80));

    // rst pulse in the middle of HOLD restarts the whole sequence.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (40) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_release(tc, tf, ok);
    check("s2_release_seen", 128'(ok), 128'(1));
    check("s2_com_release_tick", 128'(tc), 128'(64));
    check("s2_core_release_tick", 128'(tf), 128'(80));

    // Activity stretch on LED1 well past the power-on blink window.
    led_mode = {2'b11, 2'b01};
    repeat (60) step();
    cnt = 0;
    for (int k = 0; k < 21; k++) begin
      led_act[1] = (k == 0 || k == 5);
      step();
      if (led_out[1]) cnt++;
    end
    led_act = '0;
    check("act_stretch_len", 128'(cnt), 128'(14));

    // Counter wrap.
    force u_dut.tick_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release u_dut.tick_q;
    m_tick = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    check("wrap_max", 128'(tickcount64), 128'(64'hFFFF_FFFF_FFFF_FFFF));
    step();
    check("wrap_zero", 128'(tickcount64), 128'(0));
    check("wrap_stays_run", 128'(rst_core), 128'(0));

    // Soft reset request in RUN at tick 1000.
    ok = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (tickcount64 == 64'd1000) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("soft_reach_tick", 128'(ok), 128'(1));
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    t0 = 64'd1001;
    check("soft_tick_kept", 128'(tickcount64), 128'(t0));
    check("soft_core_next", 128'(rst_core), 128'(SOFT_EN));
    wait_release(tc, tf, ok);
    check("soft_release_seen", 128'(ok), 128'(1));
    check("soft_com_release_tick", 128'(tc), 128'(SOFT_EN ? t0 + 64'd64 : t0));
    check("soft_core_release_tick", 128'(tf), 128'(SOFT_EN ? t0 + 64'd80 : t0));

    // Randomised phase: mode changes, activity, occasional rst and soft requests.
    for (int k = 0; k < 3000; k++) begin
      rst          = ($urandom_range(0, 499) == 0);
      soft_rst_req = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < NL; i++) begin
        if ($urandom_range(0, 49) == 0) led_mode[2*i +: 2] = 2'($urandom_range(0, 3));
        led_act[i] = ($urandom_range(0, 5) == 0);
      end
      step();
    end
    rst          = 1'b0;
    soft_rst_req = 1'b0;
    led_act      = '0;
    repeat (3) step();
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
